// File: rtl/jt1942_obj_pkg.sv
// Shared definitions for the object line buffer and the object drawer bench:
// buffer geometry, the transparent/clear pixel value and the FSM encoding.
package jt1942_obj_pkg;

    localparam int         OBJ_AW     = 8;
    localparam int         OBJ_DW     = 4;
    localparam logic [3:0] OBJ_TRANSP = 4'hf;

    typedef enum logic {
        CLR = 1'b0,
        RUN = 1'b1
    } obj_state_t;

endpackage

// File: rtl/jt1942_objpxl_ram.sv
// One line buffer bank.
// Port A does a synchronous read and an optional same-address write, with the
// read seeing the old contents. Port B is a plain write port.
module jt1942_objpxl_ram
    import jt1942_obj_pkg::*;
#(
    parameter int AW = OBJ_AW,
    parameter int DW = OBJ_DW
) (
    input  logic          clk,
    input  logic          a_en,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    output logic [DW-1:0] a_dout,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_din
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    // read-first port A, write-only port B
    always_ff @(posedge clk) begin
        if (a_en) begin
            a_dout <= mem[a_addr];
            if (a_we) mem[a_addr] <= a_din;
        end
        if (b_we) mem[b_addr] <= b_din;
    end

endmodule

// File: rtl/jt1942_objpxl_buf.sv
// Object line buffer: ping-pong pair of 256x4 banks. The drawer fills one bank
// while the video side reads, and clears, the other one.
// Build option JT1942_OBJBUF_OVERWRITE_EN: last-wins pixel priority instead of
// the default first-wins (which needs a read-before-write on the draw bank).
//
// state | meaning
// CLR   | post-reset sweep, writes TRANSP to both banks, busy=1
// RUN   | normal drawing/reading, left only through reset
module jt1942_objpxl_buf
    import jt1942_obj_pkg::*;
#(
    parameter int            AW     = OBJ_AW,
    parameter int            DW     = OBJ_DW,
    parameter logic [DW-1:0] TRANSP = OBJ_TRANSP
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen6,
    input  logic          flip,
    input  logic [8:0]    H,
    input  logic          HINIT,
    input  logic          LHBL,
    input  logic [8:0]    posx,
    input  logic [DW-1:0] new_pxl,
    output logic          busy,
    output logic [DW-1:0] obj_pxl
);

    obj_state_t    state, state_nxt;
    logic [AW-1:0] clr_a;
    logic          wsel;
    logic          rbank;
    logic          rd_ok;
    logic [AW-1:0] rd_a;
    logic [AW-1:0] wr_a;
    logic          wr_ok;
    logic          run_cen;
    logic          unused_h8;

    logic          a_en   [2];
    logic          a_we   [2];
    logic [AW-1:0] a_addr [2];
    logic [DW-1:0] a_din  [2];
    logic [DW-1:0] a_dout [2];
    logic          b_we   [2];
    logic [AW-1:0] b_addr [2];
    logic [DW-1:0] b_din  [2];

    assign rd_a      = H[AW-1:0] ^ {AW{flip}};
    assign wr_a      = posx[AW-1:0];
    assign wr_ok     = !posx[8] && (new_pxl != TRANSP);
    assign run_cen   = (state == RUN) && cen6;
    assign unused_h8 = H[8];

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= CLR;
        else      state <= state_nxt;
    end

    // next state: sweep ends after the last address has been cleared
    always_comb begin
        state_nxt = state;
        if (state == CLR && clr_a == '1) state_nxt = RUN;
    end

    // FSM outputs
    always_comb begin
        busy = (state == CLR);
    end

    // clear sweep address, runs every clk while in CLR
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              clr_a <= '0;
        else if (state == CLR) clr_a <= clr_a + 1'b1;
    end

    // bank select and read-side output qualifiers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wsel  <= 1'b0;
            rbank <= 1'b0;
            rd_ok <= 1'b0;
        end else if (run_cen) begin
            rbank <= ~wsel;
            rd_ok <= LHBL;
            if (HINIT) wsel <= ~wsel;
        end
    end

`ifndef JT1942_OBJBUF_OVERWRITE_EN
    logic          pend_req;
    logic          pend_bank;
    logic [AW-1:0] pend_a;
    logic [DW-1:0] pend_d;
    logic          fwd;
    logic          commit;

    // The looked-up value is stale when the previous commit hit the same
    // location, so fwd marks it as already occupied.
    assign commit = pend_req && cen6 && !(fwd || a_dout[pend_bank] != TRANSP);

    // pending first-wins write, looked up this cen6 and committed on the next
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_req  <= 1'b0;
            pend_bank <= 1'b0;
            pend_a    <= '0;
            pend_d    <= TRANSP;
            fwd       <= 1'b0;
        end else if (run_cen) begin
            pend_req  <= wr_ok;
            pend_bank <= wsel;
            pend_a    <= wr_a;
            pend_d    <= new_pxl;
            fwd       <= commit && pend_a == wr_a && pend_bank == wsel;
        end
    end
`endif

    // steer both banks' ports from wsel and the FSM state
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            a_en[k]   = 1'b0;
            a_we[k]   = 1'b0;
            a_addr[k] = rd_a;
            a_din[k]  = TRANSP;
            b_we[k]   = 1'b0;
            b_addr[k] = wr_a;
            b_din[k]  = new_pxl;
            if (state == CLR) begin
                a_en[k]   = 1'b1;
                a_we[k]   = 1'b1;
                a_addr[k] = clr_a;
            end else if (wsel != 1'(k)) begin
                a_en[k] = cen6;
                a_we[k] = cen6;
            end else begin
`ifndef JT1942_OBJBUF_OVERWRITE_EN
                a_en[k]   = cen6;
                a_addr[k] = wr_a;
`endif
            end
`ifdef JT1942_OBJBUF_OVERWRITE_EN
            b_we[k] = run_cen && wr_ok && (wsel == 1'(k));
`else
            b_we[k]   = commit && (pend_bank == 1'(k));
            b_addr[k] = pend_a;
            b_din[k]  = pend_d;
`endif
        end
    end

    assign obj_pxl = rd_ok ? a_dout[rbank] : TRANSP;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        jt1942_objpxl_ram #(.AW(AW), .DW(DW)) u_ram (
            .clk    (clk),
            .a_en   (a_en[g]),
            .a_we   (a_we[g]),
            .a_addr (a_addr[g]),
            .a_din  (a_din[g]),
            .a_dout (a_dout[g]),
            .b_we   (b_we[g]),
            .b_addr (b_addr[g]),
            .b_din  (b_din[g])
        );
    end

endmodule

// File: tb/tb_jt1942_objpxl_buf.sv
// Bench for the object line buffer: line-level model of both banks plus
// directed line sequences with literal expectations.
module tb_jt1942_objpxl_buf;
    import jt1942_obj_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cen6 = 1'b0;
    logic       flip = 1'b0;
    logic [8:0] H = 9'h0;
    logic       HINIT = 1'b0;
    logic       LHBL = 1'b1;
    logic [8:0] posx = 9'h100;
    logic [3:0] new_pxl = 4'hf;
    logic       busy;
    logic [3:0] obj_pxl;

    int errors = 0;
    int checks = 0;

    jt1942_objpxl_buf dut (
        .clk     (clk),
        .rst     (rst),
        .cen6    (cen6),
        .flip    (flip),
        .H       (H),
        .HINIT   (HINIT),
        .LHBL    (LHBL),
        .posx    (posx),
        .new_pxl (new_pxl),
        .busy    (busy),
        .obj_pxl (obj_pxl)
    );

    always #5 clk = ~clk;

    // ---------------- model: two line arrays, a write-bank flag ----------
    logic [3:0] mbank [2][256];
    int         mcnt;
    logic       mw;
    logic [3:0] exp_pxl;
    logic [7:0] m_ra;
    assign m_ra = H[7:0] ^ {8{flip}};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcnt    <= 0;
            mw      <= 1'b0;
            exp_pxl <= 4'hf;
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < 256; a++)
                    mbank[b][a] <= 4'hf;
        end else if (mcnt < 256) begin
            mcnt <= mcnt + 1;
        end else if (cen6) begin
            exp_pxl         <= LHBL ? mbank[!mw][m_ra] : 4'hf;
            mbank[!mw][m_ra] <= 4'hf;
            if (!posx[8] && new_pxl != 4'hf) begin
`ifdef JT1942_OBJBUF_OVERWRITE_EN
                mbank[mw][posx[7:0]] <= new_pxl;
`else
                if (mbank[mw][posx[7:0]] == 4'hf) mbank[mw][posx[7:0]] <= new_pxl;
`endif
            end
            if (HINIT) mw <= !mw;
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (obj_pxl !== exp_pxl) begin
                errors++;
                $display("FAIL model_obj t=%0t got=%h exp=%h", $time, obj_pxl, exp_pxl);
            end
            checks++;
            if (busy !== (mcnt < 256)) begin
                errors++;
                $display("FAIL model_busy t=%0t got=%b exp=%b", $time, busy, (mcnt < 256));
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // one idle clk, then one cen6 clk with the given inputs
    task automatic step(input logic [8:0] h, input logic lhbl, input logic hi,
                        input logic [8:0] px, input logic [3:0] np);
        @(negedge clk);
        H = h; LHBL = lhbl; HINIT = hi; posx = px; new_pxl = np; cen6 = 1'b1;
        @(negedge clk);
        cen6 = 1'b0; HINIT = 1'b0; posx = 9'h100; new_pxl = 4'hf;
    endtask

    task automatic wr(input logic [8:0] px, input logic [3:0] np);
        step(9'h0C0, 1'b1, 1'b0, px, np);
    endtask

    task automatic hinit();
        step(9'h0C0, 1'b1, 1'b1, 9'h100, 4'hf);
    endtask

    task automatic rd(input logic [8:0] h, input logic lhbl);
        step(h, lhbl, 1'b0, 9'h100, 4'hf);
    endtask

    // count busy cycles from release; junk drawer/HINIT activity meanwhile
    task automatic wait_sweep(input string nm, input logic junk);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
            if (busy && junk) begin
                cen6 = n[0]; HINIT = n[0]; posx = 9'h070; new_pxl = 4'h4;
            end
        end
        cen6 = 1'b0; HINIT = 1'b0; posx = 9'h100; new_pxl = 4'hf;
        chk(nm, n, 256);
    endtask

    task automatic sweep_both(input string nm);
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < 256; a++) begin
                rd(9'(a), 1'b1);
                chk(nm, obj_pxl, 4'hf);
            end
            hinit();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_obj", obj_pxl, 4'hf);
        chk("rst_busy", busy, 1);
        rst = 1'b1;
        // 1. sweep length and empty banks
        wait_sweep("busy_len", 1'b0);
        sweep_both("init_clear");

        // 2. basic write, read, read-clear
        wr(9'h040, 4'h3);
        hinit();
        rd(9'h040, 1'b1);
        chk("basic_rd", obj_pxl, 4'h3);
        hinit();
        rd(9'h040, 1'b1);
        chk("other_bank", obj_pxl, 4'hf);
        hinit();
        rd(9'h040, 1'b1);
        chk("read_clear", obj_pxl, 4'hf);

        // 3. priority: back-to-back and spaced writes to the same x
        wr(9'h011, 4'h6);
        wr(9'h010, 4'h5);
        wr(9'h010, 4'h9);
        wr(9'h011, 4'h8);
        hinit();
        rd(9'h010, 1'b1);
`ifdef JT1942_OBJBUF_OVERWRITE_EN
        chk("prio_b2b", obj_pxl, 4'h9);
`else
        chk("prio_b2b", obj_pxl, 4'h5);
`endif
        rd(9'h011, 1'b1);
`ifdef JT1942_OBJBUF_OVERWRITE_EN
        chk("prio_spaced", obj_pxl, 4'h8);
`else
        chk("prio_spaced", obj_pxl, 4'h6);
`endif

        // 4. discard flag and transparent pixels
        wr(9'h120, 4'h2);
        wr(9'h030, 4'hf);
        hinit();
        rd(9'h020, 1'b1);
        chk("discard", obj_pxl, 4'hf);
        rd(9'h030, 1'b1);
        chk("transp_wr", obj_pxl, 4'hf);

        // 5. flip and blanking
        flip = 1'b1;
        wr(9'h000, 4'h7);
        hinit();
        rd(9'h0FF, 1'b1);
        chk("flip_rd", obj_pxl, 4'h7);
        wr(9'h000, 4'h7);
        hinit();
        rd(9'h0FF, 1'b0);
        chk("blank", obj_pxl, 4'hf);
        hinit();
        hinit();
        rd(9'h0FF, 1'b1);
        chk("blank_clear", obj_pxl, 4'hf);
        flip = 1'b0;

        // 6. reset mid-line with data in both banks
        wr(9'h050, 4'hA);
        wr(9'h051, 4'hC);
        hinit();
        wr(9'h050, 4'hB);
        rd(9'h051, 1'b1);
        chk("pre_rst", obj_pxl, 4'hC);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_obj", obj_pxl, 4'hf);
        chk("mid_rst_busy", busy, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_sweep("busy_len2", 1'b1);
        sweep_both("rst_clear");
        wr(9'h060, 4'hC);
        hinit();
        rd(9'h060, 1'b1);
        chk("post_rst_rd", obj_pxl, 4'hC);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
